// File: rtl/baccarat_dealer_pkg.sv
// +----------------------------------------------------------------------------+
// | Module : baccarat_pkg                                                      |
// | Desc   : Shared states, constants and card valuation for the dealer block. |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package baccarat_pkg;

    typedef enum logic [3:0] {
        IDLE = 4'd0,
        P1   = 4'd1,
        D1   = 4'd2,
        P2   = 4'd3,
        D2   = 4'd4,
        NAT  = 4'd5,
        PDEC = 4'd6,
        P3   = 4'd7,
        BDEC = 4'd8,
        D3   = 4'd9,
        DONE = 4'd10
    } state_t;

    localparam logic [3:0] NO_CARD = 4'd0;

    function automatic logic [3:0] card_value(input logic [3:0] code);
        return (code >= 4'd10) ? 4'd0 : code;
    endfunction

endpackage

`default_nettype wire

// File: rtl/baccarat_dealer_scorehand.sv
// +----------------------------------------------------------------------------+
// | Module : scorehand                                                         |
// | Desc   : Combinational baccarat hand total: sum of three card values mod 10.|
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module scorehand
    import baccarat_pkg::*;
(
    input  logic [3:0] card1,
    input  logic [3:0] card2,
    input  logic [3:0] card3,
    output logic [3:0] total
);

    logic [4:0] w_sum;

    assign w_sum = {1'b0, card_value(card1)} + {1'b0, card_value(card2)}
                 + {1'b0, card_value(card3)};

    // Sum is at most 27; reducing in 4-bit arithmetic is exact since results stay below 10.
    always_comb begin
        if (w_sum >= 5'd20)
            total = w_sum[3:0] - 4'd4;
        else if (w_sum >= 5'd10)
            total = w_sum[3:0] - 4'd10;
        else
            total = w_sum[3:0];
    end

endmodule

`default_nettype wire

// File: rtl/baccarat_dealer.sv
// +----------------------------------------------------------------------------+
// | Module : baccarat_dealer                                                   |
// | Desc   : Sequences one baccarat round, applies draw rules, registers result.|
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module baccarat_dealer
    import baccarat_pkg::*;
#(
    parameter bit AUTO_START = 1'b1
) (
    input  logic       slow_clock,
    input  logic       resetb,
    input  logic       start,
    input  logic       step,
    input  logic [3:0] card_in,
    output logic [3:0] pcard1,
    output logic [3:0] pcard2,
    output logic [3:0] pcard3,
    output logic [3:0] dcard1,
    output logic [3:0] dcard2,
    output logic [3:0] dcard3,
    output logic [3:0] pscore,
    output logic [3:0] dscore,
    output logic       done,
    output logic       player_win,
    output logic       dealer_win
);

    localparam state_t c_reset_state = AUTO_START ? P1 : IDLE;

    state_t     r_state, w_next;
    logic [3:0] r_pcard1, r_pcard2, r_pcard3;
    logic [3:0] r_dcard1, r_dcard2, r_dcard3;
    logic       r_done, r_player_win, r_dealer_win;

    logic       w_valid, w_load, w_clear, w_finish;
    logic       w_pnat, w_dnat, w_dealer_draw;
    logic [3:0] w_pv;
    logic [4:0] w_dsum;
    logic [3:0] w_dfinal;

    scorehand u_player (.card1(r_pcard1), .card2(r_pcard2), .card3(r_pcard3), .total(pscore));
    scorehand u_dealer (.card1(r_dcard1), .card2(r_dcard2), .card3(r_dcard3), .total(dscore));

    assign w_valid = step && (card_in != 4'd0) && (card_in <= 4'd13);
    assign w_pnat  = (pscore >= 4'd8);
    assign w_dnat  = (dscore >= 4'd8);
    assign w_pv    = card_value(r_pcard3);

    assign w_dealer_draw = (dscore <= 4'd2)
                        || (dscore == 4'd3 && w_pv != 4'd8)
                        || (dscore == 4'd4 && w_pv >= 4'd2 && w_pv <= 4'd7)
                        || (dscore == 4'd5 && w_pv >= 4'd4 && w_pv <= 4'd7)
                        || (dscore == 4'd6 && w_pv >= 4'd6 && w_pv <= 4'd7);

    // When the round ends on the D3 load, the dealer total must include the incoming card.
    assign w_dsum   = {1'b0, dscore} + {1'b0, card_value(card_in)};
    assign w_dfinal = (r_state != D3)    ? dscore :
                      (w_dsum >= 5'd10)  ? (w_dsum[3:0] - 4'd10) : w_dsum[3:0];

    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb)
            r_state <= c_reset_state;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        w_load   = 1'b0;
        w_clear  = 1'b0;
        w_finish = 1'b0;
        case (r_state)
            IDLE: if (start) begin
                w_next  = P1;
                w_clear = 1'b1;
            end
            P1: if (w_valid) begin w_load = 1'b1; w_next = D1;  end
            D1: if (w_valid) begin w_load = 1'b1; w_next = P2;  end
            P2: if (w_valid) begin w_load = 1'b1; w_next = D2;  end
            D2: if (w_valid) begin w_load = 1'b1; w_next = NAT; end
            NAT: begin
                if (w_pnat || w_dnat) begin
                    w_next   = DONE;
                    w_finish = 1'b1;
                end else begin
                    w_next = PDEC;
                end
            end
            PDEC: w_next = (pscore <= 4'd5) ? P3 : BDEC;
            P3: if (w_valid) begin w_load = 1'b1; w_next = BDEC; end
            BDEC: begin
                if ((r_pcard3 == NO_CARD) ? (dscore <= 4'd5) : w_dealer_draw) begin
                    w_next = D3;
                end else begin
                    w_next   = DONE;
                    w_finish = 1'b1;
                end
            end
            D3: if (w_valid) begin
                w_load   = 1'b1;
                w_next   = DONE;
                w_finish = 1'b1;
            end
            DONE: if (start) begin
                w_next  = P1;
                w_clear = 1'b1;
            end
            default: w_next = c_reset_state;
        endcase
    end

    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            r_pcard1     <= NO_CARD;
            r_pcard2     <= NO_CARD;
            r_pcard3     <= NO_CARD;
            r_dcard1     <= NO_CARD;
            r_dcard2     <= NO_CARD;
            r_dcard3     <= NO_CARD;
            r_done       <= 1'b0;
            r_player_win <= 1'b0;
            r_dealer_win <= 1'b0;
        end else if (w_clear) begin
            r_pcard1     <= NO_CARD;
            r_pcard2     <= NO_CARD;
            r_pcard3     <= NO_CARD;
            r_dcard1     <= NO_CARD;
            r_dcard2     <= NO_CARD;
            r_dcard3     <= NO_CARD;
            r_done       <= 1'b0;
            r_player_win <= 1'b0;
            r_dealer_win <= 1'b0;
        end else begin
            if (w_load) begin
                case (r_state)
                    P1:      r_pcard1 <= card_in;
                    D1:      r_dcard1 <= card_in;
                    P2:      r_pcard2 <= card_in;
                    D2:      r_dcard2 <= card_in;
                    P3:      r_pcard3 <= card_in;
                    D3:      r_dcard3 <= card_in;
                    default: ;
                endcase
            end
            if (w_finish) begin
                r_done       <= 1'b1;
                r_player_win <= (pscore >= w_dfinal);
                r_dealer_win <= (w_dfinal >= pscore);
            end
        end
    end

    assign pcard1     = r_pcard1;
    assign pcard2     = r_pcard2;
    assign pcard3     = r_pcard3;
    assign dcard1     = r_dcard1;
    assign dcard2     = r_dcard2;
    assign dcard3     = r_dcard3;
    assign done       = r_done;
    assign player_win = r_player_win;
    assign dealer_win = r_dealer_win;

endmodule

`default_nettype wire

// File: tb/tb_baccarat_dealer.sv
// +----------------------------------------------------------------------------+
// | Module : tb_baccarat_dealer                                                |
// | Desc   : Directed self-checking bench for baccarat_dealer.                 |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_baccarat_dealer;

    logic       slow_clock;
    logic       resetb;
    logic       start;
    logic       step;
    logic [3:0] card_in;
    logic [3:0] pcard1, pcard2, pcard3, dcard1, dcard2, dcard3;
    logic [3:0] pscore, dscore;
    logic       done, player_win, dealer_win;

    int n_checks = 0;
    int n_pass   = 0;

    baccarat_dealer #(.AUTO_START(1'b1)) dut (
        .slow_clock (slow_clock),
        .resetb     (resetb),
        .start      (start),
        .step       (step),
        .card_in    (card_in),
        .pcard1     (pcard1),
        .pcard2     (pcard2),
        .pcard3     (pcard3),
        .dcard1     (dcard1),
        .dcard2     (dcard2),
        .dcard3     (dcard3),
        .pscore     (pscore),
        .dscore     (dscore),
        .done       (done),
        .player_win (player_win),
        .dealer_win (dealer_win)
    );

    initial slow_clock = 1'b0;
    always #5 slow_clock = ~slow_clock;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Present one card with step high across a single rising edge.
    task automatic deal(input logic [3:0] c);
        step    = 1'b1;
        card_in = c;
        @(posedge slow_clock);
        #1;
        step    = 1'b0;
        card_in = 4'd0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge slow_clock);
        #1;
    endtask

    task automatic restart();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    initial begin
        resetb  = 1'b0;
        start   = 1'b0;
        step    = 1'b0;
        card_in = 4'd0;
        #12;
        check("rst_pcard1", {4'd0, pcard1}, 8'd0);
        check("rst_dcard1", {4'd0, dcard1}, 8'd0);
        check("rst_done",   {7'd0, done}, 8'd0);
        check("rst_flags",  {6'd0, player_win, dealer_win}, 8'd0);
        resetb = 1'b1;

        // Natural 9 for player
        deal(4'd4); deal(4'd2); deal(4'd5); deal(4'd3);
        check("nat_done_early", {7'd0, done}, 8'd0);
        tick(1);
        check("nat_done",   {7'd0, done}, 8'd1);
        check("nat_pscore", {4'd0, pscore}, 8'd9);
        check("nat_dscore", {4'd0, dscore}, 8'd5);
        check("nat_flags",  {6'd0, player_win, dealer_win}, 8'b10);
        check("nat_third",  {pcard3, dcard3}, 8'd0);
        tick(2);
        check("done_hold",  {7'd0, done}, 8'd1);

        // Both stand at 7: tie
        restart();
        check("restart_cards", {pcard1, dcard2}, 8'd0);
        check("restart_done",  {7'd0, done}, 8'd0);
        deal(4'd3); deal(4'd7); deal(4'd4); deal(4'd10);
        tick(2);
        check("tie_done_early", {7'd0, done}, 8'd0);
        tick(1);
        check("tie_done",   {7'd0, done}, 8'd1);
        check("tie_scores", {pscore, dscore}, {4'd7, 4'd7});
        check("tie_flags",  {6'd0, player_win, dealer_win}, 8'b11);
        check("tie_third",  {pcard3, dcard3}, 8'd0);

        // Dealer on 3 stands against a player third card of 8
        restart();
        deal(4'd2); deal(4'd1); deal(4'd1); deal(4'd2);
        tick(2);
        deal(4'd8);
        check("d3v8_pscore", {4'd0, pscore}, 8'd1);
        tick(1);
        check("d3v8_done",   {7'd0, done}, 8'd1);
        check("d3v8_dcard3", {4'd0, dcard3}, 8'd0);
        check("d3v8_scores", {pscore, dscore}, {4'd1, 4'd3});
        check("d3v8_flags",  {6'd0, player_win, dealer_win}, 8'b01);

        // Dealer on 6 draws against 7, with a king in hand
        restart();
        deal(4'd1); deal(4'd6); deal(4'd2); deal(4'd13);
        tick(2);
        deal(4'd7);
        tick(1);
        check("d6v7_nodone", {7'd0, done}, 8'd0);
        deal(4'd3);
        check("d6v7_done",   {7'd0, done}, 8'd1);
        check("d6v7_scores", {pscore, dscore}, {4'd0, 4'd9});
        check("d6v7_cards",  {pcard3, dcard3}, {4'd7, 4'd3});
        check("d6v7_flags",  {6'd0, player_win, dealer_win}, 8'b01);

        // Jack and queen count zero; player draws a 5, dealer stands on 7
        restart();
        deal(4'd12); deal(4'd3); deal(4'd11); deal(4'd4);
        check("face_pscore", {4'd0, pscore}, 8'd0);
        check("face_dscore", {4'd0, dscore}, 8'd7);
        tick(2);
        deal(4'd5);
        tick(1);
        check("face_done",  {7'd0, done}, 8'd1);
        check("face_flags", {6'd0, player_win, dealer_win}, 8'b01);

        // Step gating: invalid codes and step low must not load
        restart();
        step = 1'b1; card_in = 4'd0;  tick(1);
        check("gate_code0",  {4'd0, pcard1}, 8'd0);
        step = 1'b1; card_in = 4'd14; tick(1);
        check("gate_code14", {4'd0, pcard1}, 8'd0);
        step = 1'b0; card_in = 4'd5;  tick(1);
        check("gate_step0",  {4'd0, pcard1}, 8'd0);
        deal(4'd5);
        check("gate_load_p1", {pcard1, dcard1}, {4'd5, 4'd0});
        deal(4'd6);
        check("gate_load_d1", {4'd0, dcard1}, 8'd6);

        // Asynchronous reset between edges
        resetb = 1'b0;
        #1;
        check("arst_cards", {pcard1, dcard1}, 8'd0);
        check("arst_done",  {7'd0, done}, 8'd0);
        #1;
        resetb = 1'b1;
        tick(1);
        deal(4'd9);
        check("arst_resume", {pcard1, dcard1}, {4'd9, 4'd0});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
